writeback_scoreboard: RTL and testbench
=======================================

Name: writeback_scoreboard

Overview:
- Producer side of the register-file write port: arbitrates result writebacks from the single-cycle ALU and the multi-cycle load/store unit (LSU), and drives we/rd/write_data into the 32-entry register file.
- Keeps a per-register busy scoreboard, so issue is stalled on RAW and WAW hazards against writes still in flight.
- Sits between issue/execute and the register file.

Parameters:
- XLEN, 32, data width of results and the register-file write bus
- NREGS, 32, number of architectural registers; register 0 is hardwired zero

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- iss_valid  in  1  decoder presents an instruction for issue
- iss_rs1  in  5  source register 1
- iss_rs2  in  5  source register 2
- iss_use_rs1  in  1  instruction reads rs1
- iss_use_rs2  in  1  instruction reads rs2
- iss_rd  in  5  destination register
- iss_wr  in  1  instruction writes rd
- iss_ready  out  1  issue accepted this cycle (combinational)
- alu_valid  in  1  ALU result available; always accepted
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  LSU result available
- lsu_rd  in  5  LSU destination
- lsu_data  in  XLEN  LSU result
- lsu_ready  out  1  LSU result accepted this cycle (combinational)
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  5  register-file write address (registered)
- rf_wdata  out  XLEN  register-file write data (registered)
- busy  out  NREGS  scoreboard vector; bit 0 is always 0
- wb_err  out  1  sticky: a writeback targeted a non-busy, nonzero register

Behaviour:
- Reset (asynchronous on rst high):
  - busy = 0, rf_we = 0, rf_rd = 0, rf_wdata = 0, wb_err = 0.
  - While rst is high, iss_ready = 0 and lsu_ready = 0.
- Hazard rule:
  - hazard = (iss_use_rs1 & busy[iss_rs1]) | (iss_use_rs2 & busy[iss_rs2]) | (iss_wr & busy[iss_rd]).
  - Index 0 always reads as not busy.
- Issue handshake:
  - iss_ready = !hazard.
  - Issue fires when iss_valid & iss_ready.
  - On fire with iss_wr=1 and iss_rd!=0, busy[iss_rd] is set at the next edge.
- Writeback arbitration:
  - ALU has strict priority. alu_valid is always accepted.
  - lsu_ready = !alu_valid. The LSU holds lsu_valid/rd/data stable until accepted.
- Writeback latency:
  - A result accepted in cycle N appears on rf_we/rf_rd/rf_wdata during cycle N+1.
  - The register file commits it at the edge ending N+1.
  - If rd == 0: rf_we = 0 in N+1, and no scoreboard change.
- Busy clear:
  - busy[rf_rd] clears at the same edge at which rf_we=1 commits it, i.e. the edge ending N+1.
  - An instruction that depends on the result can issue in cycle N+2 at the earliest, and then reads the committed value.
- Simultaneous set and clear:
  - Set and clear of the same register in one cycle cannot occur, because issue to a busy rd is blocked by WAW.
  - Set and clear of different registers in one cycle are both applied.
- Error:
  - An accepted writeback with rd != 0 and busy[rd] == 0 sets wb_err, which stays set until rst.
  - The write is still forwarded to the register file.
- Reset mid-operation:
  - In-flight writebacks are discarded and rf_we drops immediately.
  - Pending LSU results are dropped; the LSU must be reset by the same rst.
- No internal FIFO: at most one writeback per cycle, and back-pressure is applied to the LSU only.

Optional Feature:
- Macro: WB_PERF_EN.
- Defined:
  - Adds output port stall_cycles (32 bits), reset to 0.
  - Increments each cycle with iss_valid & !iss_ready, saturating at 0xFFFFFFFF.
  - Adds output lsu_stall (1 bit) = lsu_valid & !lsu_ready.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Reset with rst pulsed mid-cycle asynchronously:
  - busy = 0, rf_we = 0 immediately.
  - After release, issue of rd=5 -> iss_ready=1, and busy[5]=1 next cycle.
- RAW stall:
  - Issue rd=3. Next cycle present rs1=3, use_rs1=1 -> iss_ready=0.
  - ALU writeback rd=3, data=0x1234 in cycle N -> rf_we=1, rf_rd=3, rf_wdata=0x1234 in N+1.
  - busy[3]=0 and iss_ready=1 in N+2.
- Arbitration: alu_valid and lsu_valid both high (alu_rd=4, lsu_rd=6):
  - ALU written first, lsu_ready=0.
  - Next cycle with alu_valid=0 -> lsu_ready=1, and rf_rd=6 the following cycle.
- x0 handling:
  - Issue rd=0 -> busy stays 0.
  - ALU writeback rd=0 -> rf_we=0, wb_err=0.
- Spurious writeback: ALU writeback rd=9 while busy[9]=0 -> wb_err=1, held through 100 idle cycles.
- WB_PERF_EN: hold a RAW hazard for 7 cycles -> stall_cycles=7; with the macro undefined, the build has no stall_cycles port.

Source files
------------

// File: rtl/writeback_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | writeback_scoreboard                                                   |
// | ALU/LSU writeback arbiter, register-file write port and busy scoreboard|
// | Optional macro: WB_PERF_EN (stall_cycles counter and lsu_stall output) |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module writeback_scoreboard #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iss_valid,
   input  logic [4:0]       iss_rs1,
   input  logic [4:0]       iss_rs2,
   input  logic             iss_use_rs1,
   input  logic             iss_use_rs2,
   input  logic [4:0]       iss_rd,
   input  logic             iss_wr,
   output logic             iss_ready,
   input  logic             alu_valid,
   input  logic [4:0]       alu_rd,
   input  logic [XLEN-1:0]  alu_data,
   input  logic             lsu_valid,
   input  logic [4:0]       lsu_rd,
   input  logic [XLEN-1:0]  lsu_data,
   output logic             lsu_ready,
   output logic             rf_we,
   output logic [4:0]       rf_rd,
   output logic [XLEN-1:0]  rf_wdata,
   output logic [NREGS-1:0] busy,
   output logic             wb_err
`ifdef WB_PERF_EN
  ,output logic [31:0]      stall_cycles,
   output logic             lsu_stall
`endif
);

   logic [NREGS-1:0] busy_q, busy_d;
   logic             rf_we_q, rf_we_d;
   logic [4:0]       rf_rd_q, rf_rd_d;
   logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
   logic             wb_err_q, wb_err_d;

   logic             hazard;
   logic             iss_fire;
   logic             wb_valid;
   logic [4:0]       wb_rd;
   logic [XLEN-1:0]  wb_data;

   // busy_q[0] is never set, so x0 reads as not busy without extra masking.
   always_comb begin
      hazard    = (iss_use_rs1 & busy_q[iss_rs1])
                | (iss_use_rs2 & busy_q[iss_rs2])
                | (iss_wr      & busy_q[iss_rd]);
      iss_ready = !rst && !hazard;
      lsu_ready = !rst && !alu_valid;
      iss_fire  = iss_valid & iss_ready;

      wb_valid  = alu_valid | lsu_valid;
      wb_rd     = alu_valid ? alu_rd   : lsu_rd;
      wb_data   = alu_valid ? alu_data : lsu_data;

      rf_we_d    = wb_valid && (wb_rd != 5'd0);
      rf_rd_d    = wb_valid ? wb_rd   : rf_rd_q;
      rf_wdata_d = wb_valid ? wb_data : rf_wdata_q;

      wb_err_d  = wb_err_q | (rf_we_d & !busy_q[wb_rd]);

      // Clear lands on the edge that commits the write; set and clear never collide (WAW stall).
      busy_d = busy_q;
      if (rf_we_q) begin
         busy_d[rf_rd_q] = 1'b0;
      end
      if (iss_fire && iss_wr) begin
         busy_d[iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q     <= '0;
         rf_we_q    <= 1'b0;
         rf_rd_q    <= 5'd0;
         rf_wdata_q <= '0;
         wb_err_q   <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         rf_we_q    <= rf_we_d;
         rf_rd_q    <= rf_rd_d;
         rf_wdata_q <= rf_wdata_d;
         wb_err_q   <= wb_err_d;
      end
   end

   assign busy     = busy_q;
   assign rf_we    = rf_we_q;
   assign rf_rd    = rf_rd_q;
   assign rf_wdata = rf_wdata_q;
   assign wb_err   = wb_err_q;

`ifdef WB_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (iss_valid && !iss_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign lsu_stall    = lsu_valid & !lsu_ready;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_writeback_scoreboard                                                |
// | Directed self-checking bench for writeback_scoreboard                  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_writeback_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid, iss_use_rs1, iss_use_rs2, iss_wr;
   logic [4:0]  iss_rs1, iss_rs2, iss_rd;
   logic        iss_ready;
   logic        alu_valid, lsu_valid, lsu_ready;
   logic [4:0]  alu_rd, lsu_rd;
   logic [31:0] alu_data, lsu_data;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic [31:0] busy;
   logic        wb_err;
`ifdef WB_PERF_EN
   logic [31:0] stall_cycles;
   logic        lsu_stall;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   writeback_scoreboard #(.XLEN(32), .NREGS(32)) dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
      .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2),
      .iss_rd(iss_rd), .iss_wr(iss_wr), .iss_ready(iss_ready),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .lsu_ready(lsu_ready),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
      .busy(busy), .wb_err(wb_err)
`ifdef WB_PERF_EN
     ,.stall_cycles(stall_cycles), .lsu_stall(lsu_stall)
`endif
   );

   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iss_valid = 0; iss_use_rs1 = 0; iss_use_rs2 = 0; iss_wr = 0;
      iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
   endtask

   task automatic issue_wr(input logic [4:0] rd);
      iss_valid = 1; iss_wr = 1; iss_rd = rd;
      tick();
      iss_valid = 0; iss_wr = 0; iss_rd = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      tick(); tick();
      total++; if (busy !== 32'h0) begin bad++; $display("FAIL reset_busy: got %h want %h", busy, 32'h0); end
      total++; if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'h0) begin bad++; $display("FAIL reset_rf: got we=%b rd=%0d wd=%h want 0", rf_we, rf_rd, rf_wdata); end
      total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", wb_err); end
      total++; if (iss_ready !== 1'b0 || lsu_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got iss=%b lsu=%b want 0 0", iss_ready, lsu_ready); end
      rst = 0;
      issue_wr(5'd7);
      alu_valid = 1; alu_rd = 7; alu_data = 32'hAA;
      tick();
      alu_valid = 0;
      total++; if (rf_we !== 1'b1 || busy !== 32'h80) begin bad++; $display("FAIL pre_async: got we=%b busy=%h want 1 00000080", rf_we, busy); end
      #3 rst = 1;
      #1;
      total++; if (rf_we !== 1'b0 || busy !== 32'h0) begin bad++; $display("FAIL async_reset: got we=%b busy=%h want 0 0", rf_we, busy); end
      tick();
      rst = 0;
      iss_valid = 1; iss_wr = 1; iss_rd = 5;
      #1;
      total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", iss_ready); end
      tick();
      iss_valid = 0; iss_wr = 0;
      total++; if (busy !== 32'h20) begin bad++; $display("FAIL post_reset_busy5: got %h want 00000020", busy); end
      alu_valid = 1; alu_rd = 5; alu_data = 32'h5;
      tick();
      alu_valid = 0;
      tick();
      total++; if (busy !== 32'h0) begin bad++; $display("FAIL clear5: got %h want 0", busy); end
   endtask

   task automatic test_raw();
      issue_wr(5'd3);
      iss_valid = 1; iss_rs1 = 3; iss_use_rs1 = 1;
      alu_valid = 1; alu_rd = 3; alu_data = 32'h1234;
      #1;
      total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL raw_stall: got %b want 0", iss_ready); end
      tick();
      alu_valid = 0;
      #1;
      total++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h1234) begin bad++; $display("FAIL raw_wb: got we=%b rd=%0d wd=%h want 1 3 1234", rf_we, rf_rd, rf_wdata); end
      total++; if (iss_ready !== 1'b0 || busy !== 32'h8) begin bad++; $display("FAIL raw_n1: got ready=%b busy=%h want 0 00000008", iss_ready, busy); end
      tick();
      total++; if (iss_ready !== 1'b1 || busy !== 32'h0 || rf_we !== 1'b0) begin bad++; $display("FAIL raw_n2: got ready=%b busy=%h we=%b want 1 0 0", iss_ready, busy, rf_we); end
      idle();
      // rs2 and WAW hazards, with an unused rs1 that must not stall
      issue_wr(5'd10);
      iss_rs2 = 10; iss_use_rs2 = 1;
      #1;
      total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL rs2_stall: got %b want 0", iss_ready); end
      iss_use_rs2 = 0; iss_wr = 1; iss_rd = 10;
      #1;
      total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL waw_stall: got %b want 0", iss_ready); end
      iss_wr = 0; iss_rd = 0; iss_rs1 = 10; iss_use_rs1 = 0;
      #1;
      total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL unused_rs1: got %b want 1", iss_ready); end
      idle();
      lsu_valid = 1; lsu_rd = 10; lsu_data = 32'hBEEF;
      #1;
      total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL lsu_alone_ready: got %b want 1", lsu_ready); end
      tick();
      lsu_valid = 0;
      total++; if (rf_we !== 1'b1 || rf_rd !== 5'd10 || rf_wdata !== 32'hBEEF) begin bad++; $display("FAIL lsu_wb: got we=%b rd=%0d wd=%h want 1 10 beef", rf_we, rf_rd, rf_wdata); end
      tick();
      total++; if (busy !== 32'h0) begin bad++; $display("FAIL clear10: got %h want 0", busy); end
   endtask

   task automatic test_arbitration();
      issue_wr(5'd4);
      issue_wr(5'd6);
      alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
      lsu_valid = 1; lsu_rd = 6; lsu_data = 32'h66;
      #1;
      total++; if (lsu_ready !== 1'b0) begin bad++; $display("FAIL arb_lsu_blocked: got %b want 0", lsu_ready); end
      tick();
      alu_valid = 0;
      #1;
      total++; if (rf_we !== 1'b1 || rf_rd !== 5'd4 || rf_wdata !== 32'h44) begin bad++; $display("FAIL arb_alu_first: got we=%b rd=%0d wd=%h want 1 4 44", rf_we, rf_rd, rf_wdata); end
      total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL arb_lsu_ready: got %b want 1", lsu_ready); end
      tick();
      lsu_valid = 0;
      total++; if (rf_we !== 1'b1 || rf_rd !== 5'd6 || rf_wdata !== 32'h66) begin bad++; $display("FAIL arb_lsu_wb: got we=%b rd=%0d wd=%h want 1 6 66", rf_we, rf_rd, rf_wdata); end
      // busy[6] clears at this edge while busy[8] is set
      iss_valid = 1; iss_wr = 1; iss_rd = 8;
      tick();
      iss_valid = 0; iss_wr = 0;
      total++; if (busy !== 32'h100) begin bad++; $display("FAIL set_clear_same_cycle: got %h want 00000100", busy); end
      alu_valid = 1; alu_rd = 8; alu_data = 32'h8;
      tick();
      alu_valid = 0;
      tick();
      total++; if (busy !== 32'h0 || wb_err !== 1'b0) begin bad++; $display("FAIL arb_end: got busy=%h err=%b want 0 0", busy, wb_err); end
   endtask

   task automatic test_x0();
      iss_valid = 1; iss_wr = 1; iss_rd = 0; iss_use_rs1 = 1; iss_rs1 = 0;
      #1;
      total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL x0_ready: got %b want 1", iss_ready); end
      tick();
      idle();
      total++; if (busy !== 32'h0) begin bad++; $display("FAIL x0_busy: got %h want 0", busy); end
      alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
      tick();
      alu_valid = 0;
      total++; if (rf_we !== 1'b0 || wb_err !== 1'b0) begin bad++; $display("FAIL x0_wb: got we=%b err=%b want 0 0", rf_we, wb_err); end
   endtask

   task automatic test_spurious();
      alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
      tick();
      alu_valid = 0;
      total++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 32'h99) begin bad++; $display("FAIL spur_forward: got we=%b rd=%0d wd=%h want 1 9 99", rf_we, rf_rd, rf_wdata); end
      total++; if (wb_err !== 1'b1) begin bad++; $display("FAIL spur_err: got %b want 1", wb_err); end
      repeat (100) tick();
      total++; if (wb_err !== 1'b1 || busy !== 32'h0) begin bad++; $display("FAIL spur_sticky: got err=%b busy=%h want 1 0", wb_err, busy); end
   endtask

`ifdef WB_PERF_EN
   task automatic test_perf();
      rst = 1;
      tick();
      rst = 0;
      total++; if (stall_cycles !== 32'd0 || wb_err !== 1'b0) begin bad++; $display("FAIL perf_reset: got cnt=%0d err=%b want 0 0", stall_cycles, wb_err); end
      issue_wr(5'd12);
      iss_valid = 1; iss_rs1 = 12; iss_use_rs1 = 1;
      repeat (7) tick();
      idle();
      total++; if (stall_cycles !== 32'd7) begin bad++; $display("FAIL perf_count: got %0d want 7", stall_cycles); end
      alu_valid = 1; alu_rd = 12; lsu_valid = 1; lsu_rd = 13;
      #1;
      total++; if (lsu_stall !== 1'b1) begin bad++; $display("FAIL perf_lsu_stall: got %b want 1", lsu_stall); end
      tick();
      idle();
      tick();
      total++; if (stall_cycles !== 32'd7) begin bad++; $display("FAIL perf_hold: got %0d want 7", stall_cycles); end
   endtask
`endif

   initial begin
      test_reset();
      test_raw();
      test_arbitration();
      test_x0();
      test_spurious();
`ifdef WB_PERF_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
